// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for memory_block read clients: sequencer states and
// the fixed read latency of memory_block.
package mem_stream_reader_pkg;

  // memory_block: address register plus data register.
  localparam int MEM_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Command, memory-read and fifo-push signals of the stream reader.
// master: the reader itself; slave: the surrounding memory/fifo/controller.
interface mem_stream_reader_if #(
  parameter int DATAW = 8,
  parameter int ADDRW = 9,
  parameter int LENW  = ADDRW + 1
);
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [LENW-1:0]  length;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             fifo_push;
  logic [DATAW-1:0] fifo_data;
  logic             fifo_almost_full;

  modport master (
    input  start, base_addr, length, mem_rdata, fifo_almost_full,
    output busy, done, mem_raddr, fifo_push, fifo_data
  );

  modport slave (
    output start, base_addr, length, mem_rdata, fifo_almost_full,
    input  busy, done, mem_raddr, fifo_push, fifo_data
  );
endinterface

// File: rtl/mem_stream_reader_pipeline.sv
// Generic fixed-delay register pipeline with synchronous clear.
module mem_stream_reader_pipeline #(
  parameter int WIDTH = 1,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_q [DELAY];

  // Shift data_in through DELAY stages; reset empties every stage.
  // NOTE: every stage is reset on purpose -- stale entries here would
  // become spurious outputs after reset, so this is not a data-only array.
  // NOTE: non-blocking assignments let each stage read its neighbour's
  // previous value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_out = stage_q[DELAY-1];

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side sequencer: streams LENGTH words from memory_block, starting at
// BASE_ADDR, into a downstream fifo, throttled by fifo_almost_full.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int DATAW        = 8,
  parameter int DEPTH        = 512,
  parameter int ADDRW        = $clog2(DEPTH),
  parameter int LENW         = ADDRW + 1,
  parameter int READ_LATENCY = MEM_READ_LATENCY
) (
  input logic               clk,
  input logic               rst,
  mem_stream_reader_if.master bus
);

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q;     // next address to issue
  logic [ADDRW-1:0] raddr_q;    // address presented to memory_block
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  issued_q;
  logic [LENW-1:0]  pushed_q;
  logic             capture;
  logic             issue;
  logic             push_w;
  logic [DATAW-1:0] rdata_w;
  logic [ADDRW-1:0] addr_next;

  assign addr_next = (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + ADDRW'(1);

  // Next-state and per-cycle control decode.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = (bus.length == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.fifo_almost_full) begin
          issue = 1'b1;
          if (issued_q + LENW'(1) == len_q) state_d = DRAIN;
        end
      end
      // Leave once the final in-flight word is being pushed this cycle, so
      // done lands on the cycle right after the last push.
      DRAIN: begin
        if (pushed_q + LENW'(push_w) == len_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command capture, read-address issue and transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      raddr_q  <= '0;
      len_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q   <= bus.base_addr;
        len_q    <= bus.length;
        issued_q <= '0;
        pushed_q <= '0;
      end
      if (issue) begin
        raddr_q  <= addr_q;
        addr_q   <= addr_next;
        issued_q <= issued_q + LENW'(1);
      end
      if (push_w) pushed_q <= pushed_q + LENW'(1);
    end
  end

  // One valid bit per issued read, aligned with the returning data.
  mem_stream_reader_pipeline #(
    .WIDTH (1),
    .DELAY (READ_LATENCY)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .data_in  (issue),
    .data_out (push_w)
  );

  assign rdata_w       = bus.mem_rdata;
  assign bus.fifo_data = rdata_w;
  assign bus.fifo_push = push_w;
  assign bus.mem_raddr = raddr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed testbench for mem_stream_reader with a registered-read memory
// model holding mem[i] = i[7:0] and a push/done monitor.
module tb_mem_stream_reader;
  import mem_stream_reader_pkg::*;

  localparam int DEPTH = 512;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  mem_stream_reader_if bus ();

  mem_stream_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: the reader's registered mem_raddr is the address stage,
  // this register is the data stage.
  logic [7:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

  // Monitor: every pushed word and every done pulse.
  logic [7:0] push_q [$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (!rst && bus.fifo_push === 1'b1) push_q.push_back(bus.fifo_data);
    if (!rst && bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, bus.done, 1);
  endtask

  // Base 10, length 4, no backpressure; a start coincident with done is
  // issued and must be ignored.
  task automatic basic_stream(input string t);
    int pm = push_q.size();
    int dm = done_cnt;
    bus.start = 1'b1; bus.base_addr = 9'd10; bus.length = 10'd4;
    check({t, "_c0_busy"}, bus.busy, 0);
    step();                                   // cycle 1
    bus.start = 1'b0;
    check({t, "_c1_busy"}, bus.busy, 1);
    check({t, "_c1_push"}, bus.fifo_push, 0);
    step();                                   // cycle 2
    check({t, "_c2_raddr"}, bus.mem_raddr, 10);
    check({t, "_c2_push"}, bus.fifo_push, 0);
    for (int i = 0; i < 4; i++) begin         // cycles 3..6
      step();
      check({t, "_push"}, bus.fifo_push, 1);
      check({t, "_data"}, bus.fifo_data, 10 + i);
      check({t, "_early_done"}, bus.done, 0);
    end
    step();                                   // cycle 7
    check({t, "_c7_done"}, bus.done, 1);
    check({t, "_c7_push"}, bus.fifo_push, 0);
    check({t, "_c7_busy"}, bus.busy, 1);
    bus.start = 1'b1; bus.base_addr = 9'd50; bus.length = 10'd2;
    step();                                   // cycle 8
    bus.start = 1'b0;
    check({t, "_c8_busy"}, bus.busy, 0);
    check({t, "_c8_done"}, bus.done, 0);
    repeat (6) step();
    check({t, "_busy_after"}, bus.busy, 0);
    check({t, "_push_count"}, push_q.size() - pm, 4);
    check({t, "_done_count"}, done_cnt - dm, 1);
  endtask

  initial begin
    int pm;
    int dm;
    int bad;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.fifo_almost_full = 1'b0;
    step();
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_push", bus.fifo_push, 0);
    check("rst_raddr", bus.mem_raddr, 0);
    rst = 1'b0;
    step();

    // Basic stream.
    basic_stream("basic");

    // Wrap-around: 510, 511, 0, 1.
    pm = push_q.size(); dm = done_cnt;
    bus.start = 1'b1; bus.base_addr = 9'd510; bus.length = 10'd4;
    step();
    bus.start = 1'b0;
    wait_done("wrap", 20);
    repeat (3) step();
    check("wrap_count", push_q.size() - pm, 4);
    check("wrap_done_count", done_cnt - dm, 1);
    if (push_q.size() - pm == 4) begin
      check("wrap_d0", push_q[pm],     8'd254);
      check("wrap_d1", push_q[pm + 1], 8'd255);
      check("wrap_d2", push_q[pm + 2], 8'd0);
      check("wrap_d3", push_q[pm + 3], 8'd1);
    end
    check("wrap_raddr_last", bus.mem_raddr, 1);

    // Zero length: done at cycle 1, nothing issued or pushed.
    pm = push_q.size();
    bus.start = 1'b1; bus.base_addr = 9'd77; bus.length = 10'd0;
    step();                                   // cycle 1
    bus.start = 1'b0;
    check("zero_c1_done", bus.done, 1);
    check("zero_c1_busy", bus.busy, 1);
    step();                                   // cycle 2
    check("zero_c2_done", bus.done, 0);
    check("zero_c2_busy", bus.busy, 0);
    repeat (4) step();
    check("zero_push_count", push_q.size() - pm, 0);
    check("zero_raddr", bus.mem_raddr, 1);

    // Backpressure: almost_full high during cycles 3..6.
    pm = push_q.size(); dm = done_cnt;
    bus.start = 1'b1; bus.base_addr = 9'd0; bus.length = 10'd8;
    step();                                   // cycle 1
    bus.start = 1'b0;
    step();                                   // cycle 2
    step();                                   // cycle 3
    bus.fifo_almost_full = 1'b1;
    check("bp_c3_push", bus.fifo_push, 1);
    check("bp_c3_data", bus.fifo_data, 0);
    step();                                   // cycle 4
    check("bp_c4_raddr", bus.mem_raddr, 1);
    check("bp_c4_push", bus.fifo_push, 1);
    check("bp_c4_data", bus.fifo_data, 1);
    step();                                   // cycle 5
    check("bp_c5_push", bus.fifo_push, 0);
    step();                                   // cycle 6
    check("bp_c6_raddr", bus.mem_raddr, 1);
    step();                                   // cycle 7
    bus.fifo_almost_full = 1'b0;
    check("bp_c7_raddr", bus.mem_raddr, 1);
    step();                                   // cycle 8
    check("bp_c8_raddr", bus.mem_raddr, 2);
    wait_done("bp", 30);
    repeat (3) step();
    check("bp_count", push_q.size() - pm, 8);
    check("bp_done_count", done_cnt - dm, 1);
    bad = 0;
    if (push_q.size() - pm == 8)
      for (int i = 0; i < 8; i++) if (push_q[pm + i] !== 8'(i)) bad++;
    check("bp_order_errors", bad, 0);

    // Start while busy is ignored.
    pm = push_q.size(); dm = done_cnt;
    bus.start = 1'b1; bus.base_addr = 9'd20; bus.length = 10'd4;
    step();                                   // cycle 1
    bus.start = 1'b0;
    step();                                   // cycle 2
    bus.start = 1'b1; bus.base_addr = 9'd100; bus.length = 10'd4;
    step();                                   // cycle 3
    bus.start = 1'b0;
    wait_done("busy", 20);
    repeat (10) step();
    check("busy_count", push_q.size() - pm, 4);
    check("busy_done_count", done_cnt - dm, 1);
    bad = 0;
    if (push_q.size() - pm == 4)
      for (int i = 0; i < 4; i++) if (push_q[pm + i] !== 8'(20 + i)) bad++;
    check("busy_order_errors", bad, 0);

    // Full-depth transfer from 300: every address once, wrapping.
    pm = push_q.size(); dm = done_cnt;
    bus.start = 1'b1; bus.base_addr = 9'd300; bus.length = 10'd512;
    step();
    bus.start = 1'b0;
    wait_done("full", 600);
    repeat (3) step();
    check("full_count", push_q.size() - pm, 512);
    check("full_done_count", done_cnt - dm, 1);
    bad = 0;
    if (push_q.size() - pm == 512)
      for (int i = 0; i < 512; i++)
        if (push_q[pm + i] !== 8'((300 + i) % DEPTH)) bad++;
    check("full_order_errors", bad, 0);

    // Reset at cycle 4 of a length-8 transfer.
    bus.start = 1'b1; bus.base_addr = 9'd0; bus.length = 10'd8;
    step();                                   // cycle 1
    bus.start = 1'b0;
    step();                                   // cycle 2
    step();                                   // cycle 3
    check("rstmid_c3_push", bus.fifo_push, 1);
    step();                                   // cycle 4
    rst = 1'b1;
    step();                                   // cycle 5
    rst = 1'b0;
    check("rstmid_c5_push", bus.fifo_push, 0);
    check("rstmid_c5_busy", bus.busy, 0);
    pm = push_q.size();
    repeat (6) step();
    check("rstmid_push_after", push_q.size() - pm, 0);
    check("rstmid_busy_after", bus.busy, 0);
    basic_stream("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
